// File: rtl/mandel_iterator_param.sv
// Mandelbrot escape-time iterator: z <- z^2 + c in signed fixed point, one iteration per clock.
// Latency: N+2 cycles from accept to out_val, where N is the returned iteration count.
// Backpressure: result held in DONE until out_rdy; a new point may be accepted on the release cycle.
//
// Ports:
//   clk, reset (async, active-high)
//   in_val/in_rdy, in_c_r, in_c_i, in_tag, max_iter : point input handshake
//   abort                                           : drop the point in flight (CALC/DONE)
//   out_val/out_rdy, out_iter, out_escaped, out_tag : registered result handshake
//   busy                                            : registered (state != IDLE)
module mandel_iterator_param #(
  parameter int DATA_W = 27,
  parameter int FRAC_W = 23,
  parameter int ITER_W = 11,
  parameter int TAG_W  = 19
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_val,
  output logic              in_rdy,
  input  logic [DATA_W-1:0] in_c_r,
  input  logic [DATA_W-1:0] in_c_i,
  input  logic [TAG_W-1:0]  in_tag,
  input  logic [ITER_W-1:0] max_iter,
  input  logic              abort,
  output logic              out_val,
  input  logic              out_rdy,
  output logic [ITER_W-1:0] out_iter,
  output logic              out_escaped,
  output logic [TAG_W-1:0]  out_tag,
  output logic              busy
);

  localparam int PW = 2 * DATA_W;

  typedef logic signed [DATA_W-1:0] fx_t;
  typedef logic signed [PW-1:0]     wide_t;
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  localparam wide_t MAX_W = {{(PW-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
  localparam wide_t MIN_W = {{(PW-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};
  localparam fx_t   TWO     = {{(DATA_W-FRAC_W-2){1'b0}}, 1'b1, {(FRAC_W+1){1'b0}}};
  localparam fx_t   NEG_TWO = -TWO;
  localparam logic signed [DATA_W:0] FOUR = {{(DATA_W-FRAC_W-2){1'b0}}, 1'b1, {(FRAC_W+2){1'b0}}};

  // Clamp a wide signed value into the DATA_W range.
  function automatic fx_t sat(input wide_t v);
    if (v > MAX_W)      sat = MAX_W[DATA_W-1:0];
    else if (v < MIN_W) sat = MIN_W[DATA_W-1:0];
    else                sat = v[DATA_W-1:0];
  endfunction

  state_t            state_q, state_d;
  fx_t               cr_q, ci_q, zr_q, zi_q;
  logic [TAG_W-1:0]  tag_q;
  logic [ITER_W-1:0] max_q, k_q, out_iter_q;
  logic              out_esc_q, out_val_q, busy_q;

  wide_t                p_rr, p_ii, p_ri;
  fx_t                  sq_r, sq_i, x_ri, zr_nxt, zi_nxt;
  logic signed [DATA_W:0] mag;
  logic                 esc, finish, accept;

  // Datapath for one iteration on the current z_k.
  always_comb begin
    p_rr   = wide_t'(zr_q) * wide_t'(zr_q);
    p_ii   = wide_t'(zi_q) * wide_t'(zi_q);
    p_ri   = wide_t'(zr_q) * wide_t'(zi_q);
    sq_r   = sat(p_rr >>> FRAC_W);
    sq_i   = sat(p_ii >>> FRAC_W);
    x_ri   = sat(p_ri >>> FRAC_W);
    // Squares are saturated non-negative, so DATA_W+1 bits hold the sum exactly.
    mag    = {sq_r[DATA_W-1], sq_r} + {sq_i[DATA_W-1], sq_i};
    esc    = (mag > FOUR) || (zr_q > TWO) || (zr_q < NEG_TWO) ||
             (zi_q > TWO) || (zi_q < NEG_TWO);
    finish = esc || (k_q == max_q);
    zr_nxt = sat(wide_t'(sq_r) - wide_t'(sq_i) + wide_t'(cr_q));
    zi_nxt = sat((wide_t'(x_ri) <<< 1) + wide_t'(ci_q));
  end

  // Output decode: ready is the only combinational input-to-output path.
  always_comb begin
    in_rdy = (state_q == IDLE) || ((state_q == DONE) && out_rdy);
  end

  // abort outranks accept except in IDLE, where it has no effect.
  assign accept = in_val && in_rdy && !(abort && (state_q != IDLE));

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (in_val) state_d = CALC;
      CALC: begin
        if (abort)       state_d = IDLE;
        else if (finish) state_d = DONE;
      end
      DONE: begin
        if (abort)        state_d = IDLE;
        else if (out_rdy) state_d = in_val ? CALC : IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cr_q       <= '0;
      ci_q       <= '0;
      zr_q       <= '0;
      zi_q       <= '0;
      k_q        <= '0;
      max_q      <= '0;
      tag_q      <= '0;
      out_iter_q <= '0;
      out_esc_q  <= 1'b0;
      out_val_q  <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      out_val_q <= (state_d == DONE);
      busy_q    <= (state_d != IDLE);
      if (accept) begin
        cr_q  <= fx_t'(in_c_r);
        ci_q  <= fx_t'(in_c_i);
        tag_q <= in_tag;
        max_q <= max_iter;
        zr_q  <= '0;
        zi_q  <= '0;
        k_q   <= '0;
      end else if ((state_q == CALC) && !abort) begin
        if (finish) begin
          out_iter_q <= esc ? k_q : max_q;
          out_esc_q  <= esc;
        end else begin
          zr_q <= zr_nxt;
          zi_q <= zi_nxt;
          k_q  <= k_q + 1'b1;
        end
      end
    end
  end

  // tag_q only changes on accept, which in DONE coincides with the transfer.
  assign out_val     = out_val_q;
  assign out_iter    = out_iter_q;
  assign out_escaped = out_esc_q;
  assign out_tag     = tag_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_mandel_iterator_param.sv
module tb_mandel_iterator_param;

  localparam logic signed [26:0] C_ZERO  = 27'sd0;
  localparam logic signed [26:0] C_TWO   = 27'sd16777216;
  localparam logic signed [26:0] C_NTWO  = -27'sd16777216;
  localparam logic signed [26:0] C_THREE = 27'sd25165824;
  localparam logic signed [26:0] C_HALF  = 27'sd4194304;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_val;
  logic        in_rdy;
  logic [26:0] in_c_r, in_c_i;
  logic [18:0] in_tag;
  logic [10:0] max_iter;
  logic        abort;
  logic        out_val;
  logic        out_rdy;
  logic [10:0] out_iter;
  logic        out_escaped;
  logic [18:0] out_tag;
  logic        busy;

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  int t_acc = 0;
  int n_xfer = 0;
  int lat;
  int seen;

  mandel_iterator_param dut (
    .clk(clk), .reset(reset), .in_val(in_val), .in_rdy(in_rdy),
    .in_c_r(in_c_r), .in_c_i(in_c_i), .in_tag(in_tag), .max_iter(max_iter),
    .abort(abort), .out_val(out_val), .out_rdy(out_rdy), .out_iter(out_iter),
    .out_escaped(out_escaped), .out_tag(out_tag), .busy(busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard of completed result transfers; abort suppresses a transfer.
  always @(posedge clk) if (!reset && out_val && out_rdy && !abort) n_xfer <= n_xfer + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Present a point and wait for it to be taken. Afterwards cycle T+1 has cyc == t_acc.
  task automatic send(input logic [26:0] cr, input logic [26:0] ci,
                      input logic [18:0] tag, input logic [10:0] mi);
    int ok;
    ok = 0;
    @(negedge clk);
    in_val = 1'b1; in_c_r = cr; in_c_i = ci; in_tag = tag; max_iter = mi;
    for (int i = 0; i < 50; i++) begin
      if (in_rdy) begin ok = 1; break; end
      @(negedge clk);
    end
    if (ok == 0) check("accept_timeout", 32'd0, 32'd1);
    @(posedge clk);
    #1;
    t_acc = cyc;
    in_val = 1'b0;
  endtask

  // Wait for out_val; lat = accept-to-out_val latency in cycles (N+2).
  task automatic wait_out(output int l);
    int ok;
    ok = 0;
    l = -1;
    for (int i = 0; i < 1200; i++) begin
      @(negedge clk);
      if (out_val) begin ok = 1; l = cyc - t_acc + 1; break; end
    end
    if (ok == 0) check("out_val_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    reset = 1'b1; in_val = 1'b0; in_c_r = '0; in_c_i = '0; in_tag = '0;
    max_iter = '0; abort = 1'b0; out_rdy = 1'b1;
    #12;
    check("rst_out_val", out_val, 0);
    check("rst_busy", busy, 0);
    check("rst_iter", out_iter, 0);
    check("rst_esc", out_escaped, 0);
    check("rst_tag", out_tag, 0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("rst_in_rdy", in_rdy, 1);

    // c = 2.0: z1 = 2 (|z|^2 == 4 holds), z2 = 6 escapes at k = 2.
    send(C_TWO, C_ZERO, 19'h00abc, 11'd100);
    check("c2_busy", busy, 1);
    wait_out(lat);
    check("c2_lat", lat, 4);
    check("c2_iter", out_iter, 2);
    check("c2_esc", out_escaped, 1);
    check("c2_tag", out_tag, 19'h00abc);

    // Reset during CALC at T+50.
    send(C_ZERO, C_ZERO, 19'h00055, 11'd1000);
    while (cyc < t_acc + 49) @(negedge clk);
    check("mid_busy_before", busy, 1);
    #2 reset = 1'b1;
    #1;
    check("mid_rst_busy", busy, 0);
    check("mid_rst_out_val", out_val, 0);
    check("mid_rst_iter", out_iter, 0);
    check("mid_rst_esc", out_escaped, 0);
    check("mid_rst_tag", out_tag, 0);
    @(negedge clk);
    reset = 1'b0;
    seen = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (out_val) seen++;
    end
    check("mid_rst_no_out", seen, 0);

    // c = 0 never escapes: max_iter result.
    send(C_ZERO, C_ZERO, 19'h000aa, 11'd1000);
    wait_out(lat);
    check("c0_lat", lat, 1002);
    check("c0_iter", out_iter, 1000);
    check("c0_esc", out_escaped, 0);
    check("c0_tag", out_tag, 19'h000aa);

    // c = -2.0 settles at z = 2 exactly: boundary must not escape.
    send(C_NTWO, C_ZERO, 19'h00033, 11'd50);
    wait_out(lat);
    check("cm2_lat", lat, 52);
    check("cm2_iter", out_iter, 50);
    check("cm2_esc", out_escaped, 0);

    // c = 3.0 with the consumer stalled for 5 cycles.
    @(negedge clk);
    out_rdy = 1'b0;
    send(C_THREE, C_ZERO, 19'h01234, 11'd100);
    wait_out(lat);
    check("c3_lat", lat, 3);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("stall_val", out_val, 1);
      check("stall_iter", out_iter, 1);
      check("stall_esc", out_escaped, 1);
      check("stall_tag", out_tag, 19'h01234);
      check("stall_in_rdy", in_rdy, 0);
    end
    // Release and present a max_iter = 0 point in the same cycle.
    in_val = 1'b1; in_c_r = C_HALF; in_c_i = C_HALF; in_tag = 19'h00777; max_iter = 11'd0;
    out_rdy = 1'b1;
    #1;
    check("b2b_in_rdy", in_rdy, 1);
    @(posedge clk);
    #1;
    t_acc = cyc;
    in_val = 1'b0;
    @(negedge clk);
    check("b2b_busy", busy, 1);
    check("b2b_out_val_low", out_val, 0);
    wait_out(lat);
    check("mi0_lat", lat, 2);
    check("mi0_iter", out_iter, 0);
    check("mi0_esc", out_escaped, 0);
    check("mi0_tag", out_tag, 19'h00777);

    // Abort during CALC at T+10.
    send(C_ZERO, C_ZERO, 19'h00011, 11'd1000);
    while (cyc < t_acc + 9) @(negedge clk);
    check("abort_busy_before", busy, 1);
    abort = 1'b1;
    @(posedge clk);
    #1 abort = 1'b0;
    @(negedge clk);
    check("abort_busy", busy, 0);
    check("abort_out_val", out_val, 0);
    check("abort_in_rdy", in_rdy, 1);
    seen = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (out_val) seen++;
    end
    check("abort_no_out", seen, 0);

    // Abort while out_val && out_rdy: result dropped, new point refused.
    @(negedge clk);
    out_rdy = 1'b0;
    send(C_THREE, C_ZERO, 19'h00099, 11'd10);
    wait_out(lat);
    check("abx_lat", lat, 3);
    @(negedge clk);
    abort = 1'b1; out_rdy = 1'b1;
    in_val = 1'b1; in_c_r = C_ZERO; in_c_i = C_ZERO; in_tag = 19'h00001; max_iter = 11'd5;
    @(posedge clk);
    #1;
    abort = 1'b0; in_val = 1'b0;
    @(negedge clk);
    check("abx_out_val", out_val, 0);
    check("abx_busy", busy, 0);
    repeat (20) @(negedge clk);
    check("abx_still_idle", busy, 0);
    check("xfer_total", n_xfer, 5);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/mandel_iterator_param.md
# mandel_iterator_param

Parametrised Mandelbrot escape-time iterator. It accepts one complex point c per valid/ready transfer and iterates z <- z^2 + c in signed fixed point, one iteration per clock. It returns the iteration count, an escaped flag and a caller-supplied tag. It sits between the pixel/coordinate generator and the colour-mapping and VGA-write logic; several instances may be tiled, with tags used to route results.

## Interface
Parameters:
- DATA_W, 27: total fixed-point width (signed two's complement).
- FRAC_W, 23: fraction bits; default format is 4.23.
- ITER_W, 11: width of iteration count and max_iter.
- TAG_W, 19: width of pass-through tag (e.g. packed x/y pixel address).

Ports:
- clk, in, 1: system clock.
- reset, in, 1: asynchronous, active-high reset.
- in_val, in, 1: input point valid.
- in_rdy, out, 1: block can accept a point this cycle.
- in_c_r, in, DATA_W: real part of c.
- in_c_i, in, DATA_W: imaginary part of c.
- in_tag, in, TAG_W: tag, returned unchanged with the result.
- max_iter, in, ITER_W: iteration limit, sampled at acceptance.
- abort, in, 1: synchronous cancel of the point in flight.
- out_val, out, 1: result valid.
- out_rdy, in, 1: consumer accepts result.
- out_iter, out, ITER_W: iteration count of the result.
- out_escaped, out, 1: 1 = diverged, 0 = hit max_iter.
- out_tag, out, TAG_W: tag latched with the point.
- busy, out, 1: state is not IDLE.

## Operation
- States: IDLE, CALC, DONE.
- Accept: in_val && in_rdy. On accept, latch c, tag and max_iter; clear zr, zi and k to 0; go to CALC.
- Each CALC cycle, with current z_k and k:
  - Compute zr^2, zi^2 and zr*zi, each as a 2*DATA_W-bit product.
  - Arithmetic-shift each product right by FRAC_W, then saturate to DATA_W.
  - Escape test on z_k: (zr^2 + zi^2, computed in DATA_W+1 bits) > 4.0, or |zr| > 2.0, or |zi| > 2.0. Comparisons are strict, so a value of exactly 4.0 or 2.0 does not escape.
  - If the escape test is true: out_iter = k, out_escaped = 1, go to DONE.
  - Else if k == max_iter: out_iter = max_iter, out_escaped = 0, go to DONE.
  - Else: zr <= sat(zr^2 - zi^2 + c_r), zi <= sat(2*zr*zi + c_i), k <= k + 1.
- Saturation clamps each sum to the DATA_W range: +max = 2^(DATA_W-1)-1 and -min = -2^(DATA_W-1). There is no wrap-around anywhere.
- DONE: out_val = 1. out_iter, out_escaped and out_tag are registered and held stable until out_val && out_rdy.
- On out_val && out_rdy:
  - If in_val is also high, accept the new point in the same cycle and go to CALC (back-to-back).
  - Otherwise go to IDLE.
- in_rdy = (state == IDLE) || (state == DONE && out_rdy). It is combinational from state and out_rdy. No combinational path from in_val to in_rdy.
- abort in CALC or DONE: go to IDLE next cycle and drop the result. out_val is low from the next cycle. No transfer occurs that cycle, even if out_rdy is high.
- abort in IDLE: no effect. abort has priority over accept and over output transfer.
- max_iter = 0: result is iter 0, escaped 0, after one CALC cycle.
- reset (any state, any time, asynchronous): state IDLE; out_val = 0, out_iter = 0, out_escaped = 0, out_tag = 0, busy = 0; z and k cleared; in_rdy = 1 once reset deasserts.

## Timing
- Accept at cycle T. CALC covers T+1 .. T+1+N, where N = final out_iter. out_val rises at T+N+2.
- Latency is N+2 cycles from accept to out_val.
- Throughput with out_rdy held high: one point per N+2 cycles. The accept in DONE removes the IDLE bubble.
- busy is registered and equals (state != IDLE).
- Outputs are registered. The only combinational input-to-output path is out_rdy -> in_rdy.

## Test plan
- Reset mid-CALC (c = 0, max_iter = 1000, reset at cycle T+50) -> all outputs at reset values immediately; no out_val afterwards; next point accepted normally.
- c = 0 + 0i, max_iter = 1000 -> out_iter = 1000, out_escaped = 0, out_val at T+1002.
- c = 2.0 + 0i -> z1 = 2.0 (|z|^2 = 4, no escape), z2 = 6.0 -> out_iter = 2, out_escaped = 1, out_val at T+4. Also c = -2.0 with max_iter = 50 -> 50, escaped = 0 (boundary holds).
- c = 3.0 + 0i with tag 0x1234, out_rdy low for 5 cycles -> out_iter = 1, out_escaped = 1, out_tag = 0x1234, all held stable while stalled; in_val high on the release cycle is accepted that same cycle.
- max_iter = 0, any c -> out_iter = 0, out_escaped = 0 at T+2.
- abort asserted at T+10 of a c = 0 run -> IDLE at T+11, no out_val; abort with out_val && out_rdy high -> no transfer counted by the scoreboard.
